cache_dm_responder: RTL and testbench

//   Direct-mapped, read-only cache answering the trace driver's read requests (CPU side).

---
 rtl/cache_dm_responder.sv | 176 +++++++++++++++++
 tb/tb_cache_dm_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_responder.sv
// Direct-mapped read-only byte cache with whole-line refill from a request/valid memory port.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_dm_responder #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rreq_from_cpu,
  input  logic [ADDR_W-1:0]             addr_from_cpu,
  output logic [DATA_W-1:0]             data_to_cpu,
  output logic                          hit_to_cpu,
  output logic                          rreq_to_mem,
  output logic [ADDR_W-1:0]             raddr_to_mem,
  input  logic [(DATA_W<<OFFSET_W)-1:0] rdata_from_mem,
`ifdef CACHE_STATS_EN
  input  logic                          rvalid_from_mem,
  output logic [15:0]                   hit_cnt,
  output logic [15:0]                   miss_cnt
`else
  input  logic                          rvalid_from_mem
`endif
);

  // state   | meaning
  // IDLE    | waiting for a CPU read request
  // TAG_CHK | compare captured tag against the indexed line
  // MEM_REQ | refill request outstanding, waiting for rvalid
  // REFILL  | line just written, read the requested byte
  // RESP    | hit_to_cpu pulse with the byte

  localparam int LINE_W = DATA_W << OFFSET_W;
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NLINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_TAG_CHK, S_MEM_REQ, S_REFILL, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NLINES-1:0]   valid_q, valid_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rreq_q, rreq_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;

  logic [TAG_W-1:0]    tag_mem  [NLINES];
  logic [LINE_W-1:0]   data_mem [NLINES];

  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  cur_idx;
  logic [OFFSET_W-1:0] cur_off;
  logic [LINE_W-1:0]   rd_line;
  logic [DATA_W-1:0]   rd_byte;
  logic                lookup_hit;
  logic                fill_we;

  assign cur_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_idx    = addr_q[OFFSET_W +: INDEX_W];
  assign cur_off    = addr_q[OFFSET_W-1:0];
  assign rd_line    = data_mem[cur_idx];
  assign rd_byte    = rd_line[cur_off*DATA_W +: DATA_W];
  assign lookup_hit = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    hit_d   = 1'b0;
    data_d  = '0;
    rreq_d  = rreq_q;
    raddr_d = raddr_q;
    fill_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rreq_from_cpu) begin
          addr_d  = addr_from_cpu;
          state_d = S_TAG_CHK;
        end
      end
      S_TAG_CHK: begin
        if (lookup_hit) begin
          state_d = S_RESP;
          hit_d   = 1'b1;
          data_d  = rd_byte;
        end else begin
          state_d = S_MEM_REQ;
          rreq_d  = 1'b1;
          raddr_d = {cur_tag, cur_idx, {OFFSET_W{1'b0}}};
        end
      end
      S_MEM_REQ: begin
        if (rvalid_from_mem) begin
          fill_we          = 1'b1;
          valid_d[cur_idx] = 1'b1;
          rreq_d           = 1'b0;
          state_d          = S_REFILL;
        end
      end
      S_REFILL: begin
        // array already holds the new line, so the normal read path serves it
        state_d = S_RESP;
        hit_d   = 1'b1;
        data_d  = rd_byte;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= '0;
      hit_q   <= 1'b0;
      data_q  <= '0;
      rreq_q  <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      data_q  <= data_d;
      rreq_q  <= rreq_d;
      raddr_q <= raddr_d;
    end
  end

  // tag/data arrays are not cleared; valid bits alone gate their use
  always_ff @(posedge clk) begin
    if (fill_we && !reset) begin
      tag_mem[cur_idx]  <= cur_tag;
      data_mem[cur_idx] <= rdata_from_mem;
    end
  end

  assign hit_to_cpu   = hit_q;
  assign data_to_cpu  = data_q;
  assign rreq_to_mem  = rreq_q;
  assign raddr_to_mem = raddr_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_TAG_CHK) begin
      if (lookup_hit && hit_cnt_q != 16'hFFFF)
        hit_cnt_d = hit_cnt_q + 16'd1;
      if (!lookup_hit && miss_cnt_q != 16'hFFFF)
        miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_dm_responder.sv
// Directed bench for cache_dm_responder; expected read bytes are queued per request and
// compared when hit_to_cpu pulses. Define CACHE_STATS_EN to also exercise the counters.
module tb_cache_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq_from_cpu;
  logic [12:0] addr_from_cpu;
  logic [7:0]  data_to_cpu;
  logic        hit_to_cpu;
  logic        rreq_to_mem;
  logic [12:0] raddr_to_mem;
  logic [31:0] rdata_from_mem;
  logic        rvalid_from_mem;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  cache_dm_responder dut (
    .clk             (clk),
    .reset           (reset),
    .rreq_from_cpu   (rreq_from_cpu),
    .addr_from_cpu   (addr_from_cpu),
    .data_to_cpu     (data_to_cpu),
    .hit_to_cpu      (hit_to_cpu),
    .rreq_to_mem     (rreq_to_mem),
    .raddr_to_mem    (raddr_to_mem),
    .rdata_from_mem  (rdata_from_mem),
`ifdef CACHE_STATS_EN
    .rvalid_from_mem (rvalid_from_mem),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
`else
    .rvalid_from_mem (rvalid_from_mem)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard consumer: every hit pulse must match the oldest queued byte
  always @(negedge clk) begin
    if (hit_to_cpu !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("spurious_hit", {31'd0, hit_to_cpu}, 32'd0);
      end else begin
        check("read_data", {24'd0, data_to_cpu}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_read(input logic [12:0] addr, input logic [7:0] exp_byte, input bit miss,
                         input logic [31:0] line, input int delay, input bit busy);
    exp_q.push_back(exp_byte);
    rreq_from_cpu = 1'b1;
    addr_from_cpu = addr;
    tick();
    rreq_from_cpu = 1'b0;
    check("tagchk_hit", {31'd0, hit_to_cpu}, 32'd0);
    check("tagchk_rreq", {31'd0, rreq_to_mem}, 32'd0);
    tick();
    if (!miss) begin
      check("hit_latency", {31'd0, hit_to_cpu}, 32'd1);
      check("hit_no_rreq", {31'd0, rreq_to_mem}, 32'd0);
    end else begin
      check("miss_rreq", {31'd0, rreq_to_mem}, 32'd1);
      check("miss_raddr", {19'd0, raddr_to_mem}, {19'd0, addr & 13'h1FFC});
      for (int i = 0; i < delay - 1; i++) begin
        if (busy && i == 0) begin
          rreq_from_cpu = 1'b1;
          addr_from_cpu = 13'h1FFC;
        end
        tick();
        rreq_from_cpu = 1'b0;
      end
      check("rreq_held", {31'd0, rreq_to_mem}, 32'd1);
      check("raddr_stable", {19'd0, raddr_to_mem}, {19'd0, addr & 13'h1FFC});
      rvalid_from_mem = 1'b1;
      rdata_from_mem  = line;
      tick();
      rvalid_from_mem = 1'b0;
      rdata_from_mem  = 32'h0;
      check("rreq_drop", {31'd0, rreq_to_mem}, 32'd0);
      check("refill_no_hit", {31'd0, hit_to_cpu}, 32'd0);
      tick();
      check("miss_latency", {31'd0, hit_to_cpu}, 32'd1);
    end
    tick();
    check("hit_one_cycle", {31'd0, hit_to_cpu}, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    rreq_from_cpu   = 1'b0;
    addr_from_cpu   = '0;
    rdata_from_mem  = '0;
    rvalid_from_mem = 1'b0;
    tick();
    tick();
    check("rst_hit", {31'd0, hit_to_cpu}, 32'd0);
    check("rst_data", {24'd0, data_to_cpu}, 32'd0);
    check("rst_rreq", {31'd0, rreq_to_mem}, 32'd0);
    check("rst_raddr", {19'd0, raddr_to_mem}, 32'd0);
`ifdef CACHE_STATS_EN
    check("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
`endif
    reset = 1'b0;

    // cold miss, hit in same line, conflict eviction and re-miss
    do_read(13'h0004, 8'hAA, 1'b1, 32'hDDCCBBAA, 3, 1'b0);
    do_read(13'h0007, 8'hDD, 1'b0, 32'h0, 0, 1'b0);
    do_read(13'h0104, 8'h11, 1'b1, 32'h44332211, 2, 1'b0);
    do_read(13'h0004, 8'hAA, 1'b1, 32'hDDCCBBAA, 2, 1'b0);
`ifdef CACHE_STATS_EN
    check("stats_hit_cnt", {16'd0, hit_cnt}, 32'd1);
    check("stats_miss_cnt", {16'd0, miss_cnt}, 32'd3);
`endif

    // reset while a refill is outstanding, then a late rvalid
    rreq_from_cpu = 1'b1;
    addr_from_cpu = 13'h0008;
    tick();
    rreq_from_cpu = 1'b0;
    tick();
    check("abort_rreq_up", {31'd0, rreq_to_mem}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rreq_drop", {31'd0, rreq_to_mem}, 32'd0);
    check("abort_raddr", {19'd0, raddr_to_mem}, 32'd0);
    rvalid_from_mem = 1'b1;
    rdata_from_mem  = 32'h99999999;
    tick();
    rvalid_from_mem = 1'b0;
    rdata_from_mem  = 32'h0;
    tick();
    check("late_rvalid_no_hit", {31'd0, hit_to_cpu}, 32'd0);
    check("late_rvalid_no_rreq", {31'd0, rreq_to_mem}, 32'd0);
    do_read(13'h0004, 8'hAA, 1'b1, 32'hDDCCBBAA, 1, 1'b0);
    do_read(13'h0008, 8'h5A, 1'b1, 32'h1234565A, 2, 1'b0);

    // request during refill is dropped; back-to-back read after RESP is served
    do_read(13'h0010, 8'h21, 1'b1, 32'h87654321, 4, 1'b1);
    do_read(13'h0013, 8'h87, 1'b0, 32'h0, 0, 1'b0);
    repeat (4) tick();
    check("no_pending_reads", exp_q.size(), 32'd0);
    check("idle_no_rreq", {31'd0, rreq_to_mem}, 32'd0);

`ifdef CACHE_STATS_EN
    force dut.hit_cnt_q = 16'hFFFF;
    tick();
    release dut.hit_cnt_q;
    do_read(13'h0011, 8'h43, 1'b0, 32'h0, 0, 1'b0);
    check("hit_cnt_saturate", {16'd0, hit_cnt}, 32'h0000FFFF);
    check("miss_cnt_after", {16'd0, miss_cnt}, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
